// File: rtl/nf10_10g_tx_arbiter.sv
// Packet-level round-robin arbiter muxing C_NUM_PORTS AXI4-Stream sources onto one 10G TX stream.
// Optional per-port packet counters on pkt_cnt when NF10_TX_ARB_STATS_EN is defined.
module nf10_10g_tx_arbiter #(
  parameter int unsigned C_NUM_PORTS        = 4,
  parameter int unsigned C_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                        axi_aclk,
  input  logic                                        axi_resetn,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tvalid,
  output logic [C_NUM_PORTS-1:0]                      s_axis_tready,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,
  output logic [$clog2(C_NUM_PORTS)-1:0]              grant_idx,
  output logic                                        busy
`ifdef NF10_TX_ARB_STATS_EN
  ,
  output logic [32*C_NUM_PORTS-1:0]                   pkt_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(C_NUM_PORTS);
  localparam int unsigned DW   = C_AXIS_DATA_WIDTH;
  localparam int unsigned SW   = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW   = C_AXIS_TUSER_WIDTH;

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;

  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] cand;
  logic            found;
  logic            g_valid;
  logic            g_last;
  logic [DW-1:0]   g_data;
  logic [SW-1:0]   g_strb;
  logic [UW-1:0]   g_user;
  logic            eop;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= C_NUM_PORTS; i++) begin
      cand = IdxW'((32'(last_grant_q) + i) % C_NUM_PORTS);
      if (!found && s_axis_tvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    g_strb  = '0;
    g_user  = '0;
    for (int unsigned i = 0; i < C_NUM_PORTS; i++) begin
      if (grant_q == IdxW'(i)) begin
        g_valid = s_axis_tvalid[i];
        g_last  = s_axis_tlast[i];
        g_data  = s_axis_tdata[i*DW +: DW];
        g_strb  = s_axis_tstrb[i*SW +: SW];
        g_user  = s_axis_tuser[i*UW +: UW];
      end
    end
  end

  // Payload is gated by busy so the stream reads as zero whenever nothing is granted.
  always_comb begin
    busy          = (state_q == StPkt);
    grant_idx     = grant_q;
    m_axis_tvalid = busy & g_valid;
    m_axis_tlast  = busy & g_last;
    m_axis_tdata  = busy ? g_data : '0;
    m_axis_tstrb  = busy ? g_strb : '0;
    m_axis_tuser  = busy ? g_user : '0;
    for (int unsigned i = 0; i < C_NUM_PORTS; i++) begin
      s_axis_tready[i] = busy && (grant_q == IdxW'(i)) && m_axis_tready;
    end
    eop = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (|s_axis_tvalid) begin
          grant_d = winner;
          state_d = StPkt;
        end
      end
      StPkt: begin
        if (eop) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IdxW'(C_NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef NF10_TX_ARB_STATS_EN
  logic [31:0] cnt_q [C_NUM_PORTS];
  logic [31:0] cnt_d [C_NUM_PORTS];

  always_comb begin
    for (int unsigned i = 0; i < C_NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (eop && (grant_q == IdxW'(i))) begin
        cnt_d[i] = cnt_q[i] + 32'd1;
      end
      pkt_cnt[i*32 +: 32] = cnt_q[i];
    end
  end

  always_ff @(posedge axi_aclk) begin
    for (int unsigned i = 0; i < C_NUM_PORTS; i++) begin
      if (!axi_resetn) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`endif

endmodule
